// File: rtl/fft8_out_serializer.sv
// ---------------------------------------------------------------------------
// fft8_out_serializer
//
// Takes a parallel 8-point complex FFT result (one strobe, all eight bins at
// once) and streams it out one bin per cycle under a valid/ready handshake.
// Two frame buffers are used ping-pong style. While one frame is being
// drained, the next one can be captured, so back-to-back frames stream
// without a gap.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   vld_in       : one-cycle strobe, a full frame is on fft_din_re/im
//   fft_din_re   : 8 real parts, bin k at [(k+1)*W-1 -: W]
//   fft_din_im   : 8 imaginary parts, same packing
//   rdy_in       : downstream ready
//   vld_out      : serial sample valid
//   fft_dout_re  : real part of the current bin
//   fft_dout_im  : imaginary part of the current bin
//   dout_idx     : bin index of the current sample
//   dout_last    : current sample is bin 7 of its frame
//   ovf_flag     : sticky, a frame arrived with both buffers full and was lost
// ---------------------------------------------------------------------------
module fft8_out_serializer #(
    parameter int FFT_DATA_WD = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       vld_in,
    input  logic [8*FFT_DATA_WD-1:0]   fft_din_re,
    input  logic [8*FFT_DATA_WD-1:0]   fft_din_im,
    input  logic                       rdy_in,
    output logic                       vld_out,
    output logic [FFT_DATA_WD-1:0]     fft_dout_re,
    output logic [FFT_DATA_WD-1:0]     fft_dout_im,
    output logic [2:0]                 dout_idx,
    output logic                       dout_last,
    output logic                       ovf_flag
);

    // Frame storage: [buffer][bin]. Samples are stored exactly as received.
    logic [FFT_DATA_WD-1:0] buf_re [0:1][0:7];
    logic [FFT_DATA_WD-1:0] buf_im [0:1][0:7];

    // Unpacked view of the incoming frame
    logic [FFT_DATA_WD-1:0] din_re_bin [0:7];
    logic [FFT_DATA_WD-1:0] din_im_bin [0:7];

    logic [1:0] cnt;        // number of buffered frames, 0..2
    logic       wr_ptr;     // buffer the next accepted frame goes into
    logic       rd_ptr;     // buffer currently being drained
    logic [2:0] rd_idx;     // bin currently presented on the output
    logic       ovf_q;

    logic       xfer;       // a sample is handed over this cycle
    logic       final_xfer; // ... and it is bin 7, so the read buffer frees up
    logic       accept;     // the incoming frame is captured this cycle
    logic       drop;       // the incoming frame is lost this cycle

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            din_re_bin[k] = fft_din_re[(k+1)*FFT_DATA_WD-1 -: FFT_DATA_WD];
            din_im_bin[k] = fft_din_im[(k+1)*FFT_DATA_WD-1 -: FFT_DATA_WD];
        end
    end

    // A full block still accepts a frame when the last sample of the read
    // frame leaves in the same cycle: wr_ptr then equals rd_ptr, and the
    // buffer being overwritten is exactly the one that is freed at this edge.
    always_comb begin
        xfer       = (cnt != 2'd0) && rdy_in;
        final_xfer = xfer && (rd_idx == 3'd7);
        accept     = vld_in && ((cnt != 2'd2) || final_xfer);
        drop       = vld_in && !accept;
    end

    // Control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            rd_idx <= 3'd0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (final_xfer) begin
                rd_ptr <= ~rd_ptr;
            end
            if (xfer) begin
                rd_idx <= rd_idx + 3'd1;    // wraps 7 -> 0 at frame end
            end
            case ({accept, final_xfer})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;        // none, or one in and one out
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Frame buffers. They are cleared on reset so the outputs read zero
    // until the first frame arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) begin
                    buf_re[b][k] <= '0;
                    buf_im[b][k] <= '0;
                end
            end
        end else if (accept) begin
            for (int k = 0; k < 8; k++) begin
                buf_re[wr_ptr][k] <= din_re_bin[k];
                buf_im[wr_ptr][k] <= din_im_bin[k];
            end
        end
    end

    // Outputs are decoded from registered state only, so vld_in/rdy_in
    // never reach an output combinationally and a stalled sample stays put.
    always_comb begin
        vld_out     = (cnt != 2'd0);
        fft_dout_re = buf_re[rd_ptr][rd_idx];
        fft_dout_im = buf_im[rd_ptr][rd_idx];
        dout_idx    = rd_idx;
        dout_last   = (cnt != 2'd0) && (rd_idx == 3'd7);
        ovf_flag    = ovf_q;
    end

endmodule

// File: tb/tb_fft8_out_serializer.sv
module tb_fft8_out_serializer;

    localparam int W = 10;

    logic           clk;
    logic           rst_n;
    logic           vld_in;
    logic [8*W-1:0] fft_din_re;
    logic [8*W-1:0] fft_din_im;
    logic           rdy_in;
    logic           vld_out;
    logic [W-1:0]   fft_dout_re;
    logic [W-1:0]   fft_dout_im;
    logic [2:0]     dout_idx;
    logic           dout_last;
    logic           ovf_flag;

    fft8_out_serializer #(.FFT_DATA_WD(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld_in      (vld_in),
        .fft_din_re  (fft_din_re),
        .fft_din_im  (fft_din_im),
        .rdy_in      (rdy_in),
        .vld_out     (vld_out),
        .fft_dout_re (fft_dout_re),
        .fft_dout_im (fft_dout_im),
        .dout_idx    (dout_idx),
        .dout_last   (dout_last),
        .ovf_flag    (ovf_flag)
    );

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [2:0]   idx;
    } samp_t;

    samp_t q[$];
    int    total   = 0;
    int    bad     = 0;
    int    xfer_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame for one cycle: bin k re = a+k, im = b-k.
    // Expected samples are queued when push=1 (frame known to be accepted).
    task automatic drive_frame(input int a, input int b, input bit push);
        samp_t s;
        for (int k = 0; k < 8; k++) begin
            fft_din_re[(k+1)*W-1 -: W] = W'(a + k);
            fft_din_im[(k+1)*W-1 -: W] = W'(b - k);
            if (push) begin
                s.re  = W'(a + k);
                s.im  = W'(b - k);
                s.idx = 3'(k);
                q.push_back(s);
            end
        end
        vld_in = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        vld_in = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_empty(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0 && !vld_out) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_vld"},  {31'b0, vld_out},   32'd0);
        chk({tag, "_last"}, {31'b0, dout_last}, 32'd0);
        chk({tag, "_idx"},  {29'b0, dout_idx},  32'd0);
        chk({tag, "_re"},   {22'b0, fft_dout_re}, 32'd0);
        chk({tag, "_im"},   {22'b0, fft_dout_im}, 32'd0);
        chk({tag, "_ovf"},  {31'b0, ovf_flag},  32'd0);
    endtask

    // Scoreboard monitor: every valid cycle must present the oldest pending
    // sample; it is retired only when the handshake completes.
    always @(negedge clk) begin
        samp_t e;
        if (rst_n && vld_out) begin
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL extra_sample: observed idx=%0d re=%0h expected no sample", dout_idx, fft_dout_re);
            end
            if (q.size() != 0) begin
                e = q[0];
                chk("sb_re",   {22'b0, fft_dout_re}, {22'b0, e.re});
                chk("sb_im",   {22'b0, fft_dout_im}, {22'b0, e.im});
                chk("sb_idx",  {29'b0, dout_idx},    {29'b0, e.idx});
                chk("sb_last", {31'b0, dout_last},   {31'b0, (e.idx == 3'd7)});
                if (rdy_in) begin
                    e = q.pop_front();
                    xfer_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rst_n      = 1'b0;
        vld_in     = 1'b0;
        rdy_in     = 1'b1;
        fft_din_re = '0;
        fft_din_im = '0;

        // Reset state
        cycles(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        cycles(2);
        chk("idle_vld", {31'b0, vld_out}, 32'd0);

        // Single frame, re=k+1, im=-(k+1), full-rate drain
        xfer_cnt = 0;
        drive_frame(1, -1, 1'b1);
        idle();
        chk("single_first_vld", {31'b0, vld_out}, 32'd1);
        chk("single_first_idx", {29'b0, dout_idx}, 32'd0);
        cycles(8);
        chk("single_xfers", xfer_cnt, 32'd8);
        chk("single_end_vld", {31'b0, vld_out}, 32'd0);

        // Backpressure: rdy toggles 1,0,1,0...
        xfer_cnt = 0;
        drive_frame(100, 50, 1'b1);
        idle();
        for (int i = 0; i < 16; i++) begin
            rdy_in = (i % 2 == 0);
            @(posedge clk); #1;
        end
        rdy_in = 1'b1;
        wait_empty("bp_drain", 20);
        chk("bp_xfers", xfer_cnt, 32'd8);

        // Two back-to-back frames stream gap-free
        xfer_cnt = 0;
        drive_frame(200, -200, 1'b1);
        drive_frame(300, -300, 1'b1);
        idle();
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            if (vld_out) hi++;
            @(posedge clk); #1;
        end
        chk("b2b_contig", hi, 32'd15);
        chk("b2b_end_vld", {31'b0, vld_out}, 32'd0);
        chk("b2b_xfers", xfer_cnt, 32'd16);
        chk("b2b_ovf", {31'b0, ovf_flag}, 32'd0);

        // Overflow: both buffers full, third frame lost
        xfer_cnt = 0;
        rdy_in = 1'b0;
        drive_frame(10, 20, 1'b1);
        drive_frame(30, 40, 1'b1);
        drive_frame(500, 500, 1'b0);
        idle();
        chk("ovf_set", {31'b0, ovf_flag}, 32'd1);
        cycles(3);
        chk("ovf_stall_idx", {29'b0, dout_idx}, 32'd0);
        rdy_in = 1'b1;
        cycles(16);
        chk("ovf_xfers", xfer_cnt, 32'd16);
        chk("ovf_end_vld", {31'b0, vld_out}, 32'd0);
        chk("ovf_sticky", {31'b0, ovf_flag}, 32'd1);

        // Reset clears the sticky flag
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst2");
        cycles(2);
        rst_n = 1'b1;
        cycles(1);

        // Full block, new frame coincides with final transfer of frame 1
        xfer_cnt = 0;
        drive_frame(7, 70, 1'b1);
        drive_frame(17, 170, 1'b1);
        idle();
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (dout_last) begin
                hi = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("coinc_last_seen", hi, 32'd1);
        drive_frame(27, 270, 1'b1);
        idle();
        chk("coinc_ovf", {31'b0, ovf_flag}, 32'd0);
        wait_empty("coinc_drain", 40);
        chk("coinc_xfers", xfer_cnt, 32'd24);
        chk("coinc_ovf_end", {31'b0, ovf_flag}, 32'd0);

        // Reset mid-frame (idx 3, two frames buffered)
        drive_frame(40, 41, 1'b1);
        drive_frame(60, 61, 1'b1);
        idle();
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (dout_idx == 3'd3) begin
                hi = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("midrst_idx3_seen", hi, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        chk("midrst_idle_vld", {31'b0, vld_out}, 32'd0);
        xfer_cnt = 0;
        drive_frame(-5, 5, 1'b1);
        idle();
        chk("midrst_first_vld", {31'b0, vld_out}, 32'd1);
        chk("midrst_first_idx", {29'b0, dout_idx}, 32'd0);
        wait_empty("midrst_drain", 20);
        chk("midrst_xfers", xfer_cnt, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft8_out_serializer.md
FFT8_OUT_SERIALIZER -- requirements
Module: fft8_out_serializer

Interface
REQ-001 Parameter FFT_DATA_WD, default 10, width of one real or imaginary sample.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 vld_in  input  1  one-cycle strobe: a parallel 8-point result is present on fft_din_re/im.
REQ-005 fft_din_re  input  8*FFT_DATA_WD  bin k real part at bits [(k+1)*FFT_DATA_WD-1 -: FFT_DATA_WD], k=0..7, natural order.
REQ-006 fft_din_im  input  8*FFT_DATA_WD  bin k imaginary part, same packing as fft_din_re.
REQ-007 rdy_in  input  1  downstream ready.
REQ-008 vld_out  output  1  serial sample valid.
REQ-009 fft_dout_re  output  FFT_DATA_WD  current bin real part.
REQ-010 fft_dout_im  output  FFT_DATA_WD  current bin imaginary part.
REQ-011 dout_idx  output  3  bin index of current sample.
REQ-012 dout_last  output  1  high when dout_idx==7 and vld_out==1.
REQ-013 ovf_flag  output  1  sticky: a vld_in frame was dropped.

Function
REQ-014 Two frame buffers (ping-pong), each 8 complex samples; occupancy counter cnt in 0..2; write pointer wr_ptr and read pointer rd_ptr, 1 bit each.
REQ-015 Frame accepted on vld_in when cnt<2, or when cnt==2 and the final transfer (idx 7 handshake) of the read frame occurs in the same cycle; frame captured whole into buffer wr_ptr; wr_ptr toggles.
REQ-016 vld_in with cnt==2 and no concurrent final transfer: frame dropped, buffers unchanged, ovf_flag set to 1 on the next edge.
REQ-017 vld_out = (cnt!=0), derived from registered state only; no combinational path from vld_in or rdy_in to any output.
REQ-018 fft_dout_re/im = buffer rd_ptr, bin dout_idx.
REQ-019 Transfer = vld_out && rdy_in; on transfer dout_idx increments modulo 8.
REQ-020 On transfer with dout_idx==7: rd_ptr toggles, cnt decrements (net unchanged if a frame is accepted the same cycle).
REQ-021 With vld_out=1 and rdy_in=0, all outputs hold stable.
REQ-022 Latency: frame accepted at edge N with cnt==0 -> vld_out=1, dout_idx=0 from cycle N+1; with rdy_in held 1, 8 samples on 8 consecutive cycles.
REQ-023 Back-to-back frames with rdy_in=1 stream gap-free: idx 7 of frame A followed directly by idx 0 of frame B.
REQ-024 Frames output in arrival order; samples of one frame never interleave with another frame.
REQ-025 Data passes unmodified, no arithmetic, no rounding.

Reset
REQ-026 rst_n low asynchronously: cnt=0, wr_ptr=0, rd_ptr=0, dout_idx=0, ovf_flag=0, vld_out=0, dout_last=0, buffer contents 0 (so fft_dout_re/im=0).
REQ-027 Reset mid-frame discards all buffered data; first vld_in after release is treated as into an empty block.
REQ-028 ovf_flag cleared only by reset.

Verification
REQ-029 Single frame, bins re=k+1, im=-(k+1), rdy_in=1 -> vld_out cycles N+1..N+8, idx 0..7, re 1..8, im -1..-8, dout_last only at idx 7.
REQ-030 Backpressure: rdy_in toggled 1,0,1,0 -> each sample held while rdy_in=0, 8 transfers total, no duplication or skip.
REQ-031 Two frames on consecutive cycles, rdy_in=1 -> 16 contiguous valid cycles, frame A then frame B, ovf_flag=0.
REQ-032 rdy_in=0, three vld_in strobes -> first two kept, third dropped, ovf_flag=1; after rdy_in=1 exactly 16 samples (frames 1,2).
REQ-033 cnt==2, vld_in coincident with frame-1 idx 7 transfer -> new frame accepted, ovf_flag stays 0, 24 samples total.
REQ-034 rst_n asserted at idx 3 with cnt==2 -> outputs immediately reset values; next frame starts at idx 0 one cycle after acceptance.
